// File: rtl/tcdm_bank_pkg.sv
// Shared types and helpers for the multi-bank TCDM memory model.
// Build option: TCDM_BANK_WRITE_RESP_EN (writes also return a response).
package tcdm_bank_pkg;

  localparam int unsigned MaxLatency   = 4;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefIdWidth   = 1;

  typedef struct packed {
    logic [DefDataWidth-1:0] data;
    logic [DefIdWidth-1:0]   id;
  } resp_t;

  // Word index inside a bank: drop the byte offset, wrap to bank size.
  function automatic int unsigned word_idx(
    input logic [31:0] add,
    input int unsigned n_words
  );
    return (add >> 2) & (n_words - 1);
  endfunction

endpackage

// File: rtl/tcdm_bank_resp_fifo.sv
// Fall-through response FIFO for one TCDM bank.
// Build option: none (see tcdm_bank_array for TCDM_BANK_WRITE_RESP_EN).
module tcdm_bank_resp_fifo
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter type         T     = resp_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_q, wr_d;
  logic [PtrW-1:0] rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_empty;
  logic            bypass;
  logic            store;
  logic            rd_adv;

  assign is_empty = (cnt_q == '0);
  // An empty FIFO hands the incoming entry straight to the output.
  assign bypass   = is_empty && push_i && pop_i;
  assign store    = push_i && !bypass;
  assign rd_adv   = pop_i && !is_empty;

  assign full_o   = (cnt_q == CntW'(Depth));
  assign empty_o  = is_empty && !push_i;
  assign data_o   = is_empty ? data_i : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (store) begin
      wr_d = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
    end
    if (rd_adv) begin
      rd_d = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
    end
    if (store && !rd_adv) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!store && rd_adv) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (store) begin
        mem_q[wr_q] <= data_i;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full_o && !pop_i))
        else $error("resp fifo overflow");
      assert (!(pop_i && empty_o))
        else $error("resp fifo underflow");
    end
  end
`endif

endmodule

// File: rtl/tcdm_bank_array.sv
// Multi-bank TCDM target model with read latency and response backpressure.
// Build option: TCDM_BANK_WRITE_RESP_EN (writes also return a response).
module tcdm_bank_array
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned NumBanks     = 4,
  parameter int unsigned NumBankWords = 256,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned IdWidth      = 1,
  parameter int unsigned Latency      = 1,
  parameter int unsigned RespDepth    = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumBanks-1:0]                   req_i,
  output logic [NumBanks-1:0]                   gnt_o,
  input  logic [NumBanks-1:0]                   wen_i,
  input  logic [NumBanks-1:0][AddrWidth-1:0]    add_i,
  input  logic [NumBanks-1:0][DataWidth-1:0]    data_i,
  input  logic [NumBanks-1:0][DataWidth/8-1:0]  be_i,
  input  logic [NumBanks-1:0][IdWidth-1:0]      id_i,
  output logic [NumBanks-1:0]                   r_valid_o,
  input  logic [NumBanks-1:0]                   r_ready_i,
  output logic [NumBanks-1:0][DataWidth-1:0]    r_data_o,
  output logic [NumBanks-1:0][IdWidth-1:0]      r_id_o
);

  localparam int unsigned CntW  = $clog2(RespDepth + 1);
  localparam int unsigned BeW   = DataWidth / 8;
  localparam int unsigned WordW = $clog2(NumBankWords);

`ifdef TCDM_BANK_WRITE_RESP_EN
  localparam bit WriteResp = 1'b1;
`else
  localparam bit WriteResp = 1'b0;
`endif

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [IdWidth-1:0]   id;
  } bank_resp_t;

  typedef struct packed {
    logic       valid;
    bank_resp_t resp;
  } pipe_t;

  if (Latency < 1 || Latency > MaxLatency) begin : g_bad_latency
    $error("Latency must be in 1..%0d", MaxLatency);
  end
  if (RespDepth < Latency) begin : g_bad_depth
    $error("RespDepth must be >= Latency");
  end
  if ((NumBankWords & (NumBankWords - 1)) != 0) begin : g_bad_words
    $error("NumBankWords must be a power of 2");
  end
  if ((DataWidth % 8) != 0) begin : g_bad_width
    $error("DataWidth must be a multiple of 8");
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank

    logic [DataWidth-1:0] mem_q [NumBankWords];
    logic [CntW-1:0]      outst_q, outst_d;
    pipe_t                pipe_q [Latency];
    pipe_t                pipe_d [Latency];
    logic [WordW-1:0]     widx;
    logic                 accept;
    logic                 gen;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    bank_resp_t           head;

    assign widx   = WordW'(word_idx(32'(add_i[b]), NumBankWords));
    // Grant depends only on the registered count, so every slot a
    // response can land in is reserved before the request is taken.
    assign gnt_o[b] = (outst_q < CntW'(RespDepth));
    assign accept = req_i[b] && gnt_o[b];
    assign gen    = accept && (wen_i[b] || WriteResp);
    assign pop    = r_valid_o[b] && r_ready_i[b];

    always_comb begin
      outst_d = outst_q;
      unique case ({gen, pop})
        2'b10:   outst_d = outst_q + 1'b1;
        2'b01:   outst_d = outst_q - 1'b1;
        default: ;
      endcase
    end

    always_comb begin
      pipe_d[0]           = '0;
      pipe_d[0].valid     = gen;
      pipe_d[0].resp.id   = id_i[b];
      if (gen && wen_i[b]) begin
        pipe_d[0].resp.data = mem_q[widx];
      end
      for (int i = 1; i < Latency; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        outst_q <= '0;
        for (int i = 0; i < Latency; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        outst_q <= outst_d;
        pipe_q  <= pipe_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (accept && !wen_i[b]) begin
        for (int j = 0; j < BeW; j++) begin
          if (be_i[b][j]) begin
            mem_q[widx][j*8 +: 8] <= data_i[b][j*8 +: 8];
          end
        end
      end
    end

    tcdm_bank_resp_fifo #(
      .Depth (RespDepth),
      .T     (bank_resp_t)
    ) i_resp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (pipe_q[Latency-1].valid),
      .data_i  (pipe_q[Latency-1].resp),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_o  (head)
    );

    assign r_valid_o[b] = !fifo_empty;
    assign r_data_o[b]  = r_valid_o[b] ? head.data : '0;
    assign r_id_o[b]    = r_valid_o[b] ? head.id : '0;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        assert (outst_q <= CntW'(RespDepth))
          else $error("outstanding count above RespDepth");
        assert (!(fifo_full && pipe_q[Latency-1].valid && !pop))
          else $error("response arrived at a full FIFO");
      end
    end
`endif

  end

endmodule
